lut_ram_1w1r: RTL and testbench

// - Parameterised LUT-based RAM: one synchronous write port, one asynchronous (combinational) read port.
// - Generic storage primitive for the RV32I core (register-file style arrays, small data stores).
// - Write-then-read in the same cycle returns OLD data until the clock edge commits the write.

---
 rtl/lut_ram_1w1r_if.sv | 18 +
 rtl/lut_ram_1w1r.sv | 54 +++++
 tb/tb_lut_ram_1w1r.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_ram_1w1r_if.sv
// rtl/lut_ram_1w1r_if.sv - signal bundle for lut_ram_1w1r with a passive monitor view
interface lut_ram_1w1r_if #(
  parameter int LUT_WIDTH = 32,
  parameter int ADDR_W    = 8
) (
  input logic clk
);
  logic                 rst;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [LUT_WIDTH-1:0] wr_data;
  logic [ADDR_W-1:0]    rd_addr;
  logic [LUT_WIDTH-1:0] rd_data;

  modport monitor (
    input clk, rst, wr_en, wr_addr, wr_data, rd_addr, rd_data
  );
endinterface

// File: rtl/lut_ram_1w1r.sv
// rtl/lut_ram_1w1r.sv - LUT RAM, one synchronous write port, one combinational read port
module lut_ram_1w1r #(
  parameter int  LUT_WIDTH = 32,
  parameter int  LUT_DEPTH = 256,
  localparam int ADDR_W    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [LUT_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [LUT_WIDTH-1:0] rd_data
);
  // One extra bit so a power-of-two depth still fits the compare constant.
  localparam logic [ADDR_W:0] DEPTH_C = LUT_DEPTH[ADDR_W:0];

  logic [LUT_WIDTH-1:0] mem_q [LUT_DEPTH];
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 rst_seen_q;
  logic                 rst_seen_d;

  always_comb begin
    wr_ok      = wr_en && ({1'b0, wr_addr} < DEPTH_C);
    rd_ok      = {1'b0, rd_addr} < DEPTH_C;
    rst_seen_d = rst_seen_q | rst;
    rd_data    = '0;
    if (rd_ok) begin
      rd_data = mem_q[rd_addr];
    end
  end

  // Reset wins over a coincident write; addresses past the depth never alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rst_seen_q <= rst_seen_d;
  end

  a_rd_known: assert property (@(posedge clk)
    (rst_seen_q && !rst && rd_ok) |-> !$isunknown(rd_data));

  a_wr_commit: assert property (@(posedge clk)
    ($past(!rst && wr_ok)) |-> (mem_q[$past(wr_addr)] == $past(wr_data)));
endmodule

// File: tb/tb_lut_ram_1w1r.sv
// tb/tb_lut_ram_1w1r.sv - scoreboard bench for lut_ram_1w1r at width 32, depth 1000
module tb_lut_ram_1w1r;
  localparam int W  = 32;
  localparam int D  = 1000;
  localparam int AW = 10;

  logic clk;
  lut_ram_1w1r_if #(.LUT_WIDTH(W), .ADDR_W(AW)) bus (.clk(clk));

  lut_ram_1w1r #(.LUT_WIDTH(W), .LUT_DEPTH(D)) dut (
    .clk     (bus.clk),
    .rst     (bus.rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  logic [W-1:0] model [D];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_v;
  int total;
  int bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a);
    if (int'(a) < D) return model[a];
    return '0;
  endfunction

  task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic [AW-1:0] ra);
    bus.rst     = r;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr = ra;
    #1;
  endtask

  task automatic edge_step;
    @(posedge clk);
    if (bus.rst) begin
      for (int i = 0; i < D; i++) model[i] = '0;
    end else if (bus.wr_en && int'(bus.wr_addr) < D) begin
      model[bus.wr_addr] = bus.wr_data;
    end
    #1;
  endtask

  task automatic test_reset;
    logic [AW-1:0] addrs [4];
    addrs[0] = 10'd0; addrs[1] = 10'd1; addrs[2] = 10'd500; addrs[3] = 10'd998;
    drive(1'b1, 1'b0, '0, '0, '0);
    edge_step();
    drive(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 10'd5);
    edge_step();
    exp_q.push_back(32'hDEADBEEF);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL rst_prewrite got=%h exp=%h", bus.rd_data, exp_v);
    end
    drive(1'b1, 1'b0, '0, '0, 10'd5);
    edge_step();
    drive(1'b0, 1'b0, '0, '0, 10'd5);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL rst_rd5 got=%h exp=%h", bus.rd_data, exp_v);
    end
    drive(1'b0, 1'b0, '0, '0, 10'd999);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL rst_rd999 got=%h exp=%h", bus.rd_data, exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, '0, addrs[i]);
      exp_q.push_back(32'h0);
      exp_v = exp_q.pop_front(); total++;
      if (bus.rd_data !== exp_v) begin
        bad++; $display("FAIL rst_sweep addr=%0d got=%h exp=%h", addrs[i], bus.rd_data, exp_v);
      end
    end
  endtask

  task automatic test_read_before_write;
    drive(1'b0, 1'b1, 10'd17, 32'hA5A5A5A5, 10'd17);
    edge_step();
    drive(1'b0, 1'b1, 10'd17, 32'h12345678, 10'd17);
    exp_q.push_back(32'hA5A5A5A5);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL rbw_before got=%h exp=%h", bus.rd_data, exp_v);
    end
    edge_step();
    exp_q.push_back(32'h12345678);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL rbw_after got=%h exp=%h", bus.rd_data, exp_v);
    end
  endtask

  task automatic test_write_disabled;
    drive(1'b0, 1'b1, 10'd3, 32'h00000001, 10'd3);
    edge_step();
    drive(1'b0, 1'b0, 10'd3, 32'hFFFFFFFF, 10'd3);
    edge_step();
    exp_q.push_back(32'h00000001);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL wr_disabled got=%h exp=%h", bus.rd_data, exp_v);
    end
  endtask

  task automatic test_boundaries;
    drive(1'b0, 1'b1, 10'd0, 32'hCAFEF00D, 10'd0);
    edge_step();
    drive(1'b0, 1'b1, 10'd999, 32'h0BADC0DE, 10'd999);
    edge_step();
    exp_q.push_back(32'h0BADC0DE);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL bnd_rd999 got=%h exp=%h", bus.rd_data, exp_v);
    end
    drive(1'b0, 1'b1, 10'd1000, 32'hDEADDEAD, 10'd1000);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL oor_before got=%h exp=%h", bus.rd_data, exp_v);
    end
    edge_step();
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL oor_after got=%h exp=%h", bus.rd_data, exp_v);
    end
    drive(1'b0, 1'b1, 10'd1023, 32'h13572468, 10'd1023);
    edge_step();
    drive(1'b0, 1'b0, '0, '0, 10'd1023);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL oor_rd1023 got=%h exp=%h", bus.rd_data, exp_v);
    end
    drive(1'b0, 1'b0, '0, '0, 10'd0);
    exp_q.push_back(32'hCAFEF00D);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL bnd_rd0 got=%h exp=%h", bus.rd_data, exp_v);
    end
    drive(1'b0, 1'b0, '0, '0, 10'd999);
    exp_q.push_back(32'h0BADC0DE);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL bnd_rd999_kept got=%h exp=%h", bus.rd_data, exp_v);
    end
  endtask

  task automatic test_reset_collision;
    drive(1'b0, 1'b1, 10'd8, 32'h00000055, 10'd8);
    edge_step();
    drive(1'b1, 1'b1, 10'd8, 32'h00000077, 10'd8);
    edge_step();
    drive(1'b0, 1'b0, '0, '0, 10'd8);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); total++;
    if (bus.rd_data !== exp_v) begin
      bad++; $display("FAIL rst_collision got=%h exp=%h", bus.rd_data, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 10'(100 + i), 32'h01010101 * (i + 1), 10'(100 + i));
      edge_step();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, '0, '0, 10'(100 + i));
      exp_q.push_back(32'h01010101 * (i + 1));
      exp_v = exp_q.pop_front(); total++;
      if (bus.rd_data !== exp_v) begin
        bad++; $display("FAIL b2b addr=%0d got=%h exp=%h", 100 + i, bus.rd_data, exp_v);
      end
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return 10'd0;
      1:       return 10'd999;
      2:       return 10'(1000 + $urandom_range(0, 23));
      default: return 10'($urandom_range(0, 999));
    endcase
  endfunction

  function automatic logic [W-1:0] pick_data();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random;
    logic          r;
    logic          we;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [W-1:0]  wd;
    for (int n = 0; n < 1000; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      we = 1'($urandom_range(0, 1));
      wa = pick_addr();
      wd = pick_data();
      ra = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
      drive(r, we, wa, wd, ra);
      exp_q.push_back(model_rd(ra));
      exp_v = exp_q.pop_front(); total++;
      if (bus.rd_data !== exp_v) begin
        bad++; $display("FAIL rand_before n=%0d ra=%0d got=%h exp=%h", n, ra, bus.rd_data, exp_v);
      end
      edge_step();
      exp_q.push_back(model_rd(ra));
      exp_v = exp_q.pop_front(); total++;
      if (bus.rd_data !== exp_v) begin
        bad++; $display("FAIL rand_after n=%0d ra=%0d got=%h exp=%h", n, ra, bus.rd_data, exp_v);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < D; i++) model[i] = '0;
    bus.rst     = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    test_reset();
    test_read_before_write();
    test_write_disabled();
    test_boundaries();
    test_reset_collision();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
